// File: rtl/ble_link_types_pkg.sv
// Shared types for the BLE link sequencer: state encoding, counter width
// and a saturating nibble increment used for the attempt counter.
package ble_link_types_pkg;

  localparam int CNT_W = 24;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    BOOT_WAIT = 3'd1,
    SETUP     = 3'd2,
    BACKOFF   = 3'd3,
    LINK_UP   = 3'd4,
    ERROR     = 3'd5
  } ble_link_state_t;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : (v + 4'd1);
  endfunction

endpackage

// File: rtl/ble_delay_cnt.sv
// Loadable down-counter shared by the boot wait and the retry backoff.
// Stops at zero instead of wrapping; load has priority over enable.
module ble_delay_cnt
  import ble_link_types_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != {CNT_W{1'b0}})) begin
      cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == {CNT_W{1'b0}});

endmodule

// File: rtl/ble_link_ctrl.sv
// BLE UART link sequencer: boot delay, AT setup with retry/backoff, then
// hands the single TX FIFO write port over to the runtime data path.
module ble_link_ctrl
  import ble_link_types_pkg::*;
#(
  parameter logic [CNT_W-1:0] BOOT_DELAY_CYC    = 24'd1_000_000,
  parameter logic [CNT_W-1:0] RETRY_BACKOFF_CYC = 24'd500_000,
  parameter logic [3:0]       MAX_SETUP_TRIES   = 4'd3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       setup_done,
  input  logic       setup_fail,
  output logic       setting_up,
  input  logic       s_byte_ready,
  input  logic [7:0] s_cmd_byte,
  input  logic       d_byte_valid,
  input  logic [7:0] d_byte,
  output logic       d_ready,
  input  logic       tx_full,
  output logic       tx_wr,
  output logic [7:0] tx_data,
  output logic       link_up,
  output logic       link_err,
  output logic       tx_ovf,
  output logic [3:0] attempts
);

  ble_link_state_t  state_q, state_d;
  logic [3:0]       attempts_q, attempts_d;
  logic             tx_wr_q, tx_wr_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             link_up_q, link_up_d;
  logic             link_err_q, link_err_d;
  logic             tx_ovf_q, tx_ovf_d;
  logic             cnt_load, cnt_en, cnt_zero;
  logic [CNT_W-1:0] cnt_load_val;

  ble_delay_cnt u_delay_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .en       (cnt_en),
    .zero     (cnt_zero)
  );

  assign setting_up = (state_q == SETUP) && !setup_done && !setup_fail;
  assign d_ready    = (state_q == LINK_UP) && !tx_full;

  // Next state, counter control and TX mux, all keyed off the registered state
  always_comb begin
    state_d      = state_q;
    attempts_d   = attempts_q;
    link_err_d   = link_err_q;
    tx_ovf_d     = tx_ovf_q;
    tx_wr_d      = 1'b0;
    tx_data_d    = tx_data_q;
    cnt_load     = 1'b0;
    cnt_load_val = {CNT_W{1'b0}};
    cnt_en       = 1'b0;

    // Dropping start aborts from anywhere; nothing in flight is forwarded
    if (!start && (state_q != IDLE)) begin
      state_d  = IDLE;
      cnt_load = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          attempts_d = 4'd0;
          link_err_d = 1'b0;
          tx_ovf_d   = 1'b0;
          if (start) begin
            state_d      = BOOT_WAIT;
            cnt_load     = 1'b1;
            cnt_load_val = BOOT_DELAY_CYC - 24'd1;
          end else begin
            state_d = IDLE;
          end
        end
        BOOT_WAIT, BACKOFF: begin
          cnt_en = 1'b1;
          if (cnt_zero) begin
            state_d    = SETUP;
            attempts_d = sat_inc4(attempts_q);
          end else begin
            state_d = state_q;
          end
        end
        SETUP: begin
          if (setup_fail) begin
            if (attempts_q >= MAX_SETUP_TRIES) begin
              state_d    = ERROR;
              link_err_d = 1'b1;
            end else begin
              state_d      = BACKOFF;
              cnt_load     = 1'b1;
              cnt_load_val = RETRY_BACKOFF_CYC - 24'd1;
            end
          end else if (setup_done) begin
            state_d = LINK_UP;
          end else begin
            state_d = SETUP;
          end
          if (s_byte_ready) begin
            if (!tx_full) begin
              tx_wr_d   = 1'b1;
              tx_data_d = s_cmd_byte;
            end else begin
              tx_ovf_d = 1'b1;
            end
          end else begin
            tx_wr_d = 1'b0;
          end
        end
        LINK_UP: begin
          if (d_byte_valid && d_ready) begin
            tx_wr_d   = 1'b1;
            tx_data_d = d_byte;
          end else begin
            tx_wr_d = 1'b0;
          end
        end
        ERROR: begin
          link_err_d = 1'b1;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    link_up_d = (state_d == LINK_UP);
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      attempts_q <= 4'd0;
      tx_wr_q    <= 1'b0;
      tx_data_q  <= 8'd0;
      link_up_q  <= 1'b0;
      link_err_q <= 1'b0;
      tx_ovf_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      attempts_q <= attempts_d;
      tx_wr_q    <= tx_wr_d;
      tx_data_q  <= tx_data_d;
      link_up_q  <= link_up_d;
      link_err_q <= link_err_d;
      tx_ovf_q   <= tx_ovf_d;
    end
  end

  assign tx_wr    = tx_wr_q;
  assign tx_data  = tx_data_q;
  assign link_up  = link_up_q;
  assign link_err = link_err_q;
  assign tx_ovf   = tx_ovf_q;
  assign attempts = attempts_q;

endmodule

// File: tb/tb_ble_link_ctrl.sv
// Scoreboard bench for ble_link_ctrl with short delays (boot 10, backoff 5,
// 3 tries); expected TX bytes are queued by stimulus and popped by a monitor.
module tb_ble_link_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       setup_done;
  logic       setup_fail;
  logic       setting_up;
  logic       s_byte_ready;
  logic [7:0] s_cmd_byte;
  logic       d_byte_valid;
  logic [7:0] d_byte;
  logic       d_ready;
  logic       tx_full;
  logic       tx_wr;
  logic [7:0] tx_data;
  logic       link_up;
  logic       link_err;
  logic       tx_ovf;
  logic [3:0] attempts;

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  ble_link_ctrl #(
    .BOOT_DELAY_CYC    (24'd10),
    .RETRY_BACKOFF_CYC (24'd5),
    .MAX_SETUP_TRIES   (4'd3)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .setup_done   (setup_done),
    .setup_fail   (setup_fail),
    .setting_up   (setting_up),
    .s_byte_ready (s_byte_ready),
    .s_cmd_byte   (s_cmd_byte),
    .d_byte_valid (d_byte_valid),
    .d_byte       (d_byte),
    .d_ready      (d_ready),
    .tx_full      (tx_full),
    .tx_wr        (tx_wr),
    .tx_data      (tx_data),
    .link_up      (link_up),
    .link_err     (link_err),
    .tx_ovf       (tx_ovf),
    .attempts     (attempts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every TX write must match the next queued byte
  always @(negedge clk) begin
    if (tx_wr === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL tx_unexpected: got tx_data=%02h, required no write", tx_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (tx_data !== e) begin
          failures++;
          $display("FAIL tx_data: got %02h, required %02h", tx_data, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Steps until setting_up rises, bounded; n = steps taken
  task automatic wait_su(output int n);
    n = 0;
    while (setting_up !== 1'b1 && n < 100) begin
      step();
      n++;
    end
  endtask

  task automatic fail_pulse();
    setup_fail = 1'b1;
    #1;
    chk("setting_up_in_fail_pulse", setting_up, 1'b0);
    step();
    setup_fail = 1'b0;
  endtask

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; setup_done = 1'b0; setup_fail = 1'b0;
    s_byte_ready = 1'b0; s_cmd_byte = 8'h00; d_byte_valid = 1'b0; d_byte = 8'h00;
    tx_full = 1'b0;
    step(); step();
    chk("rst_tx_wr", tx_wr, 1'b0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_link_up", link_up, 1'b0);
    chk("rst_link_err", link_err, 1'b0);
    chk("rst_tx_ovf", tx_ovf, 1'b0);
    chk("rst_attempts", attempts, 4'd0);
    chk("rst_setting_up", setting_up, 1'b0);
    chk("rst_d_ready", d_ready, 1'b0);
    rst_n = 1'b1;
    step();

    // Boot timing
    start = 1'b1;
    wait_su(n);
    chk("boot_cycles", n, 11);
    chk("boot_attempts", attempts, 4'd1);

    // Setup bytes forwarded, then one dropped on tx_full
    s_byte_ready = 1'b1; s_cmd_byte = 8'h41; exp_q.push_back(8'h41);
    step();
    s_cmd_byte = 8'h0D; exp_q.push_back(8'h0D);
    step();
    chk("ovf_before_full", tx_ovf, 1'b0);
    s_cmd_byte = 8'h99; tx_full = 1'b1;
    step();
    chk("full_no_write", tx_wr, 1'b0);
    chk("tx_ovf_set", tx_ovf, 1'b1);
    s_byte_ready = 1'b0; tx_full = 1'b0;

    // setup_done with a byte in the same cycle: byte still forwarded
    setup_done = 1'b1; s_byte_ready = 1'b1; s_cmd_byte = 8'h4F; exp_q.push_back(8'h4F);
    #1;
    chk("setting_up_in_done_pulse", setting_up, 1'b0);
    step();
    setup_done = 1'b0; s_byte_ready = 1'b0;
    chk("link_up_after_done", link_up, 1'b1);
    chk("attempts_link", attempts, 4'd1);

    // Data path
    d_byte_valid = 1'b1; d_byte = 8'h55; exp_q.push_back(8'h55);
    #1;
    chk("d_ready_free", d_ready, 1'b1);
    step();
    tx_full = 1'b1; d_byte = 8'h66;
    #1;
    chk("d_ready_full", d_ready, 1'b0);
    step();
    chk("data_full_no_write", tx_wr, 1'b0);
    tx_full = 1'b0; d_byte_valid = 1'b0; s_byte_ready = 1'b1; s_cmd_byte = 8'h77;
    step();
    chk("setup_byte_in_link", tx_wr, 1'b0);
    s_byte_ready = 1'b0;

    // Drop start mid-stream
    start = 1'b0; d_byte_valid = 1'b1; d_byte = 8'h88;
    step();
    d_byte_valid = 1'b0;
    chk("abort_tx_wr", tx_wr, 1'b0);
    chk("abort_link_up", link_up, 1'b0);
    chk("abort_d_ready", d_ready, 1'b0);
    step();
    chk("idle_attempts", attempts, 4'd0);
    chk("idle_tx_ovf", tx_ovf, 1'b0);

    // Retry exhaustion
    start = 1'b1;
    wait_su(n);
    chk("retry_boot_cycles", n, 11);
    chk("retry_att1", attempts, 4'd1);
    fail_pulse();
    wait_su(n);
    chk("backoff1_cycles", n, 5);
    chk("retry_att2", attempts, 4'd2);
    fail_pulse();
    wait_su(n);
    chk("backoff2_cycles", n, 5);
    chk("retry_att3", attempts, 4'd3);
    fail_pulse();
    chk("error_link_err", link_err, 1'b1);
    chk("error_setting_up", setting_up, 1'b0);
    step(); step(); step();
    chk("error_sticky", link_err, 1'b1);
    chk("error_attempts", attempts, 4'd3);
    start = 1'b0;
    step(); step();
    chk("err_idle_link_err", link_err, 1'b0);
    chk("err_idle_attempts", attempts, 4'd0);

    // Simultaneous done+fail: fail wins
    start = 1'b1;
    wait_su(n);
    chk("dual_boot_cycles", n, 11);
    setup_done = 1'b1; setup_fail = 1'b1;
    step();
    setup_done = 1'b0; setup_fail = 1'b0;
    chk("dual_link_up", link_up, 1'b0);
    chk("dual_setting_up", setting_up, 1'b0);
    wait_su(n);
    chk("dual_backoff_cycles", n, 5);
    chk("dual_attempts", attempts, 4'd2);

    // Reset during BACKOFF
    fail_pulse();
    step();
    rst_n = 1'b0; start = 1'b0;
    step();
    chk("rst2_tx_wr", tx_wr, 1'b0);
    chk("rst2_link_up", link_up, 1'b0);
    chk("rst2_attempts", attempts, 4'd0);
    chk("rst2_tx_data", tx_data, 8'h00);
    chk("rst2_setting_up", setting_up, 1'b0);
    rst_n = 1'b1;
    step(); step();

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
